// File: rtl/instr_encoder.sv
// RV32I field packer: range-checks the immediate, encodes the instruction word and
// streams it to imem through a ready/valid write port at an auto-incrementing address.
//
// state  | meaning
// -------+-----------------------------------------------
// EMPTY  | no word held, wr_en low
// FULL   | word held on wr_data/wr_addr, wr_en high
module instr_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ready,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic        is_shift;
  logic        fits12, fits13, fits21;
  logic [31:0] enc_word;
  logic        enc_bad;
  logic        accept, complete;

  // An immediate fits N signed bits when all bits above N-1 replicate the sign.
  assign fits12   = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits13   = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits21   = (imm[31:20] == '0) || (imm[31:20] == '1);
  assign is_shift = (fmt == 3'd1) && (opcode == 7'b0010011) &&
                    ((funct3 == 3'b001) || (funct3 == 3'b101));

  always_comb begin
    enc_word = '0;
    enc_bad  = 1'b0;
    case (fmt)
      3'd0: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: begin
        if (is_shift) begin
          enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
          enc_bad  = (imm[31:5] != '0);
        end else begin
          enc_word = {imm[11:0], rs1, funct3, rd, opcode};
          enc_bad  = !fits12;
        end
      end
      3'd2: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_bad  = !fits12;
      end
      3'd3: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_bad  = !fits13 || imm[0];
      end
      3'd4: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_bad  = (imm[11:0] != '0);
      end
      3'd5: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_bad  = !fits21 || imm[0];
      end
      default: enc_bad = 1'b1;
    endcase
  end

  // start blocks both acceptance and completion of the held word.
  assign in_ready = !start && ((state_q == S_EMPTY) || wr_ready);
  assign accept   = in_valid && in_ready;
  assign complete = (state_q == S_FULL) && wr_ready && !start;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = S_EMPTY;
      addr_d  = BASE;
      err_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      if (complete) begin
        addr_d  = addr_q + 1'b1;
        state_d = S_EMPTY;
      end
      if (accept) begin
        if (enc_bad) begin
          err_d = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else begin
          data_d  = enc_word;
          state_d = S_FULL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      addr_q  <= BASE;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wr_en   = (state_q == S_FULL);
  assign wr_addr = addr_q;
  assign wr_data = data_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus a randomized run checked
// against a transaction-level model and an immediate-decoder round trip.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, wr_ready;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  logic        in_ready, wr_en, err;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  err_cnt;

  logic        in_ready2, wr_en2, err2;
  logic [1:0]  wr_addr2;
  logic [31:0] wr_data2;
  logic [7:0]  err_cnt2;

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .err(err), .err_cnt(err_cnt)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .wr_ready(wr_ready), .err(err2), .err_cnt(err_cnt2)
  );

  // ---------------- reference model ----------------
  function automatic bit ref_shift(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3);
    return (f == 3'd1) && (op == OP_IMM) && (f3 == 3'd1 || f3 == 3'd5);
  endfunction

  function automatic bit ref_reject(input logic [2:0] f, input logic [6:0] op,
                                    input logic [2:0] f3, input logic [31:0] im);
    int s;
    s = int'(im);
    case (f)
      3'd0: return 1'b0;
      3'd1: if (ref_shift(f, op, f3)) return (s < 0) || (s > 31);
            else return (s < -2048) || (s > 2047);
      3'd2: return (s < -2048) || (s > 2047);
      3'd3: return (s < -4096) || (s > 4094) || (im[0] == 1'b1);
      3'd4: return (im % 32'd4096) != 32'd0;
      3'd5: return (s < -1048576) || (s > 1048574) || (im[0] == 1'b1);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_encode(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] w;
    w = 32'(op);
    case (f)
      3'd0: w = w | (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7);
      3'd1: begin
        if (ref_shift(f, op, f3)) w = w | (32'(f7) << 25) | ((im & 32'd31) << 20);
        else w = w | ((im & 32'hFFF) << 20);
        w = w | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7);
      end
      3'd2: w = w | (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                  | (32'(f3) << 12) | ((im & 32'd31) << 7);
      3'd3: w = w | (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'd63) << 25)
                  | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
                  | (((im >> 1) & 32'd15) << 8) | (((im >> 11) & 32'd1) << 7);
      3'd4: w = w | (im & 32'hFFFFF000) | (32'(d) << 7);
      3'd5: w = w | (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                  | (((im >> 11) & 32'd1) << 20) | (im & 32'h000FF000) | (32'(d) << 7);
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // Decode-stage immediate generator, used for the round-trip invariant.
  function automatic logic [31:0] immgen(input logic [2:0] f, input logic [31:0] w);
    case (f)
      3'd1: return {{20{w[31]}}, w[31:20]};
      3'd2: return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4: return {w[31:12], 12'b0};
      3'd5: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tuple(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    set_tuple(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    step(); step();
    rst = 1'b0;
    #1;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
    tests++; if (wr_data !== 32'd0) begin fails++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    tests++; if (wr_addr !== 10'd0) begin fails++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    tests++; if (err !== 1'b0 || err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err: got %0b/%0d want 0/0", err, err_cnt); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_addi();
    do_start();
    wr_ready = 1'b1;
    set_tuple(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    tests++; if (wr_en !== 1'b1 || wr_addr !== 10'd0) begin fails++; $display("FAIL addi_wr: got en=%0b addr=%0d want 1/0", wr_en, wr_addr); end
    tests++; if (wr_data !== 32'hFFF0_0093) begin fails++; $display("FAIL addi_data: got %h want fff00093", wr_data); end
    step();
    tests++; if (wr_en !== 1'b0 || wr_addr !== 10'd1) begin fails++; $display("FAIL addi_done: got en=%0b addr=%0d want 0/1", wr_en, wr_addr); end
  endtask

  task automatic test_back_to_back();
    do_start();
    wr_ready = 1'b1;
    set_tuple(3'd3, OP_BR, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
    in_valid = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready0: got %0b want 1", in_ready); end
    step();
    set_tuple(3'd4, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready1: got %0b want 1", in_ready); end
    tests++; if (wr_en !== 1'b1 || wr_addr !== 10'd0 || wr_data !== 32'hFE20_8EE3) begin fails++; $display("FAIL b2b_beq: got en=%0b addr=%0d data=%h want 1/0/fe208ee3", wr_en, wr_addr, wr_data); end
    step();
    in_valid = 1'b0;
    tests++; if (wr_en !== 1'b1 || wr_addr !== 10'd1 || wr_data !== 32'h1234_52B7) begin fails++; $display("FAIL b2b_lui: got en=%0b addr=%0d data=%h want 1/1/123452b7", wr_en, wr_addr, wr_data); end
    step();
    tests++; if (wr_en !== 1'b0 || wr_addr !== 10'd2) begin fails++; $display("FAIL b2b_done: got en=%0b addr=%0d want 0/2", wr_en, wr_addr); end
  endtask

  task automatic test_jal_err();
    do_start();
    wr_ready = 1'b1;
    set_tuple(3'd5, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    in_valid = 1'b1;
    step();
    tests++; if (wr_en !== 1'b1 || wr_data !== 32'h0010_00EF) begin fails++; $display("FAIL jal_data: got en=%0b data=%h want 1/001000ef", wr_en, wr_data); end
    set_tuple(3'd5, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    step();
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL jal_rej_wr_en: got %0b want 0", wr_en); end
    tests++; if (err !== 1'b1 || err_cnt !== 8'd1) begin fails++; $display("FAIL jal_rej_err: got %0b/%0d want 1/1", err, err_cnt); end
    tests++; if (wr_addr !== 10'd1) begin fails++; $display("FAIL jal_rej_addr: got %0d want 1", wr_addr); end
    set_tuple(3'd1, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    step();
    in_valid = 1'b0;
    tests++; if (wr_en !== 1'b1 || wr_addr !== 10'd1 || wr_data !== 32'h0070_0113) begin fails++; $display("FAIL jal_next: got en=%0b addr=%0d data=%h want 1/1/00700113", wr_en, wr_addr, wr_data); end
    step();
  endtask

  task automatic test_backpressure();
    do_start();
    wr_ready = 1'b0;
    set_tuple(3'd1, OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1;
    step();
    set_tuple(3'd4, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready%0d: got %0b want 0", i, in_ready); end
      tests++; if (wr_en !== 1'b1 || wr_addr !== 10'd0 || wr_data !== 32'h0050_0193) begin fails++; $display("FAIL bp_hold%0d: got en=%0b addr=%0d data=%h want 1/0/00500193", i, wr_en, wr_addr, wr_data); end
      step();
    end
    wr_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests++; if (wr_en !== 1'b1 || wr_addr !== 10'd1 || wr_data !== 32'h1234_52B7) begin fails++; $display("FAIL bp_next: got en=%0b addr=%0d data=%h want 1/1/123452b7", wr_en, wr_addr, wr_data); end
    step();
  endtask

  task automatic test_wrap_and_start();
    do_start();
    wr_ready = 1'b1;
    set_tuple(3'd7, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      set_tuple(3'd1, OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
      step();
      tests++; if (wr_en2 !== 1'b1 || wr_addr2 !== 2'(i % 4)) begin fails++; $display("FAIL wrap_addr%0d: got en=%0b addr=%0d want 1/%0d", i, wr_en2, wr_addr2, i % 4); end
    end
    tests++; if (err2 !== 1'b1) begin fails++; $display("FAIL wrap_err_pre: got %0b want 1", err2); end
    start = 1'b1;
    #1;
    tests++; if (in_ready2 !== 1'b0) begin fails++; $display("FAIL start_ready: got %0b want 0", in_ready2); end
    step();
    start = 1'b0;
    in_valid = 1'b0;
    tests++; if (wr_en2 !== 1'b0 || wr_addr2 !== 2'd0) begin fails++; $display("FAIL start_drop: got en=%0b addr=%0d want 0/0", wr_en2, wr_addr2); end
    tests++; if (err2 !== 1'b0 || err_cnt2 !== 8'd0) begin fails++; $display("FAIL start_err: got %0b/%0d want 0/0", err2, err_cnt2); end
    step();
    tests++; if (wr_en2 !== 1'b0 || wr_addr2 !== 2'd0) begin fails++; $display("FAIL start_idle: got en=%0b addr=%0d want 0/0", wr_en2, wr_addr2); end
  endtask

  task automatic test_saturate();
    do_start();
    wr_ready = 1'b1;
    set_tuple(3'd7, OP_IMM, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL sat_wr_en%0d: got %0b want 0", i, wr_en); end
      tests++; if (err_cnt !== 8'((i + 1 > 255) ? 255 : i + 1)) begin fails++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, err_cnt, (i + 1 > 255) ? 255 : i + 1); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic rand_tuple();
    logic [2:0]  f;
    logic [6:0]  op;
    logic [31:0] r, im;
    f  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    op = 7'($urandom);
    if (f == 3'd1 && $urandom_range(0, 1) == 1) op = OP_IMM;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: im = r;
      1: im = {{20{r[11]}}, r[11:0]};
      2: im = {{19{r[12]}}, r[12:1], 1'b0};
      3: im = {{11{r[20]}}, r[20:1], 1'b0};
      default: im = 32'($urandom_range(0, 33));
    endcase
    if (f == 3'd4 && $urandom_range(0, 3) != 0) im[11:0] = 12'd0;
    set_tuple(f, op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), im);
  endtask

  task automatic test_random();
    bit          m_held, m_err, m_chk, exp_ready;
    logic [9:0]  m_addr;
    logic [31:0] m_data, m_imm;
    logic [2:0]  m_fmt;
    int          m_cnt;
    do_start();
    m_held = 0; m_err = 0; m_chk = 0; m_addr = 10'd0; m_data = 32'd0; m_imm = 32'd0;
    m_fmt = 3'd0; m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      rand_tuple();
      in_valid = ($urandom_range(0, 3) != 0);
      wr_ready = ($urandom_range(0, 9) < 7);
      start    = ($urandom_range(0, 49) == 0);
      #1;
      exp_ready = !start && (!m_held || wr_ready);
      tests++; if (in_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready c%0d: got %0b want %0b", c, in_ready, exp_ready); end
      tests++; if (wr_en !== m_held) begin fails++; $display("FAIL rnd_wr_en c%0d: got %0b want %0b", c, wr_en, m_held); end
      if (m_held) begin
        tests++; if (wr_data !== m_data || wr_addr !== m_addr) begin fails++; $display("FAIL rnd_word c%0d: got %h@%0d want %h@%0d", c, wr_data, wr_addr, m_data, m_addr); end
        if (m_chk) begin
          tests++; if (immgen(m_fmt, wr_data) !== m_imm) begin fails++; $display("FAIL rnd_roundtrip c%0d: got %h want %h", c, immgen(m_fmt, wr_data), m_imm); end
        end
      end
      tests++; if (err !== m_err || err_cnt !== 8'(m_cnt)) begin fails++; $display("FAIL rnd_err c%0d: got %0b/%0d want %0b/%0d", c, err, err_cnt, m_err, m_cnt); end
      if (start) begin
        m_held = 0; m_addr = 10'd0; m_err = 0; m_cnt = 0;
      end else begin
        if (m_held && wr_ready) begin
          m_held = 0;
          m_addr = m_addr + 10'd1;
        end
        if (in_valid && exp_ready) begin
          if (ref_reject(fmt, opcode, funct3, imm)) begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
          end else begin
            m_held = 1;
            m_data = ref_encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
            m_imm  = imm;
            m_fmt  = fmt;
            m_chk  = (fmt != 3'd0) && !ref_shift(fmt, opcode, funct3);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_jal_err();
    test_backpressure();
    test_wrap_and_start();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
